// File: rtl/memory_stage_pkg.sv
// ---------------------------------------------------------------------------
// memory_stage_pkg
//   Shared constants and types for the memory stage: memory-op function
//   codes, writeback bubble values, the captured-op record and the
//   writeback record, plus small op-classification helpers.
// ---------------------------------------------------------------------------
package memory_stage_pkg;

    // Memory function codes (input_mem_fun)
    localparam logic [3:0] MEM_X   = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    // Writeback bubble values
    localparam logic [31:0] REGPC_NOP = 32'h0000_0000;
    localparam logic        REN_X     = 1'b0;
    localparam logic [3:0]  WB_X      = 4'd0;
    localparam logic [31:0] DATA_NOP  = 32'hffff_ffff;

    // Op captured from execute while a memory access is in flight
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  fun;
        logic [31:0] alu_out;
        logic [31:0] rs2_data;
        logic        rf_wen;
        logic [3:0]  wb_sel;
        logic [4:0]  wb_addr;
    } mem_op_t;

    // Record handed to writeback
    typedef struct packed {
        logic [31:0] pc;
        logic        rf_wen;
        logic [3:0]  wb_sel;
        logic [4:0]  wb_addr;
        logic [31:0] alu_out;
        logic [31:0] mem_rdata;
    } wb_out_t;

    localparam wb_out_t WB_BUBBLE = '{pc: REGPC_NOP, rf_wen: REN_X, wb_sel: WB_X,
                                      wb_addr: 5'd0, alu_out: DATA_NOP, mem_rdata: DATA_NOP};

    function automatic logic is_store(input logic [3:0] fun);
        return (fun == MEM_SB) || (fun == MEM_SH) || (fun == MEM_SW);
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// ---------------------------------------------------------------------------
// mem_align
//   Combinational byte-lane logic shared by the memory stage and, later,
//   the fetch/LSU path.
//   fun_i   : memory function code
//   lane_i  : address[1:0], selects byte lane
//   rs2_i   : raw store data
//   rdata_i : raw load word from memory
//   wmask_o : byte enables for stores (0 for loads)
//   wdata_o : lane-replicated store data
//   rdata_o : sign/zero-extended load data (raw word for LW)
// ---------------------------------------------------------------------------
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [3:0]  fun_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned halfwords use lane[1] only; words ignore the lane entirely.
    assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    assign half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wmask_o = 4'h0;
        wdata_o = rs2_i;
        rdata_o = rdata_i;
        case (fun_i)
            MEM_SB:  begin
                wmask_o = 4'b0001 << lane_i;
                wdata_o = {4{rs2_i[7:0]}};
            end
            MEM_SH:  begin
                wmask_o = 4'b0011 << {lane_i[1], 1'b0};
                wdata_o = {2{rs2_i[15:0]}};
            end
            MEM_SW:  wmask_o = 4'hf;
            MEM_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: rdata_o = {24'd0, byte_sel};
            MEM_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: rdata_o = {16'd0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   Stage after execute. Non-memory ops pass to writeback one cycle later.
//   A load/store is captured, issued as one valid/ready request on the data
//   port, and (for loads) held until the response returns. Stalls execute
//   while an access is outstanding. A branch flush squashes the op in flight.
//   clk, rst             : clock, asynchronous active-high reset
//   wb_branch_hazard     : flush
//   input_*              : op from execute
//   output_stall_flg     : combinational stall back to execute
//   mem_cmd_* / mem_rsp_*: data-memory request / response
//   output_*             : registered record to writeback (bubble if idle)
// ---------------------------------------------------------------------------
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_branch_hazard,
    input  logic [31:0]       input_reg_pc,
    input  logic [3:0]        input_mem_fun,
    input  logic [31:0]       input_alu_out,
    input  logic [31:0]       input_rs2_data,
    input  logic              input_rf_wen,
    input  logic [3:0]        input_wb_sel,
    input  logic [4:0]        input_wb_addr,
    output logic              output_stall_flg,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic              mem_cmd_wen,
    output logic [3:0]        mem_cmd_wmask,
    output logic [31:0]       mem_cmd_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_rdata,
    output logic [31:0]       output_reg_pc,
    output logic              output_rf_wen,
    output logic [3:0]        output_wb_sel,
    output logic [4:0]        output_wb_addr,
    output logic [31:0]       output_alu_out,
    output logic [31:0]       output_mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;  // flushed load: swallow the response

    logic [1:0] state_q, state_d;
    mem_op_t    cap_q, cap_d;
    wb_out_t    out_q, out_d;
    mem_op_t    in_op;
    wb_out_t    cap_done;
    logic       cap_store;
    logic       stall;
    logic [31:0] load_data;

    assign in_op = '{pc: input_reg_pc, fun: input_mem_fun, alu_out: input_alu_out,
                     rs2_data: input_rs2_data, rf_wen: input_rf_wen,
                     wb_sel: input_wb_sel, wb_addr: input_wb_addr};

    assign cap_store = is_store(cap_q.fun);

    mem_align u_align (
        .fun_i   (cap_q.fun),
        .lane_i  (cap_q.alu_out[1:0]),
        .rs2_i   (cap_q.rs2_data),
        .rdata_i (mem_rsp_rdata),
        .wmask_o (mem_cmd_wmask),
        .wdata_o (mem_cmd_wdata),
        .rdata_o (load_data)
    );

    assign mem_cmd_addr = {cap_q.alu_out[ADDR_W-1:2], 2'b00};
    assign mem_cmd_wen  = cap_store;

    // Completion record for the captured op; mem_rdata filled in for loads.
    assign cap_done = '{pc: cap_q.pc, rf_wen: cap_q.rf_wen, wb_sel: cap_q.wb_sel,
                        wb_addr: cap_q.wb_addr, alu_out: cap_q.alu_out,
                        mem_rdata: cap_store ? DATA_NOP : load_data};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!wb_branch_hazard && input_mem_fun != MEM_X) state_d = S_REQ;
            S_REQ:   begin
                if (wb_branch_hazard)   state_d = S_IDLE;
                else if (mem_cmd_ready) state_d = cap_store ? S_IDLE : S_WAIT;
            end
            S_WAIT:  begin
                if (mem_rsp_valid)         state_d = S_IDLE;
                else if (wb_branch_hazard) state_d = S_DRAIN;
            end
            S_DRAIN: if (mem_rsp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next-state
    always_comb begin
        mem_cmd_valid = 1'b0;
        stall         = 1'b0;
        cap_d         = cap_q;
        out_d         = WB_BUBBLE;
        case (state_q)
            S_IDLE:  begin
                stall = (input_mem_fun != MEM_X);
                if (!wb_branch_hazard) begin
                    if (input_mem_fun != MEM_X) begin
                        cap_d = in_op;
                    end else begin
                        out_d = '{pc: input_reg_pc, rf_wen: input_rf_wen, wb_sel: input_wb_sel,
                                  wb_addr: input_wb_addr, alu_out: input_alu_out,
                                  mem_rdata: DATA_NOP};
                    end
                end
            end
            S_REQ:   begin
                // Flush withdraws the request in the same cycle; a concurrent ready is moot.
                mem_cmd_valid = !wb_branch_hazard;
                stall         = !(cap_store && mem_cmd_ready);
                if (mem_cmd_valid && mem_cmd_ready && cap_store) out_d = cap_done;
            end
            S_WAIT:  begin
                stall = !mem_rsp_valid;
                if (mem_rsp_valid && !wb_branch_hazard) out_d = cap_done;
            end
            S_DRAIN: stall = 1'b1;
            default: ;
        endcase
    end

    assign output_stall_flg = stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= '0;
            out_q <= WB_BUBBLE;
        end else begin
            cap_q <= cap_d;
            out_q <= out_d;
        end
    end

    assign output_reg_pc    = out_q.pc;
    assign output_rf_wen    = out_q.rf_wen;
    assign output_wb_sel    = out_q.wb_sel;
    assign output_wb_addr   = out_q.wb_addr;
    assign output_alu_out   = out_q.alu_out;
    assign output_mem_rdata = out_q.mem_rdata;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//   Drives ops one at a time, playing both the execute stage and the data
//   memory, and compares every cycle against a transaction-level model of
//   what each op must produce.
// ---------------------------------------------------------------------------
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_branch_hazard;
    logic [31:0] input_reg_pc;
    logic [3:0]  input_mem_fun;
    logic [31:0] input_alu_out;
    logic [31:0] input_rs2_data;
    logic        input_rf_wen;
    logic [3:0]  input_wb_sel;
    logic [4:0]  input_wb_addr;
    logic        output_stall_flg;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic [31:0] mem_cmd_addr;
    logic        mem_cmd_wen;
    logic [3:0]  mem_cmd_wmask;
    logic [31:0] mem_cmd_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic [31:0] output_reg_pc;
    logic        output_rf_wen;
    logic [3:0]  output_wb_sel;
    logic [4:0]  output_wb_addr;
    logic [31:0] output_alu_out;
    logic [31:0] output_mem_rdata;

    int    n_tests = 0;
    int    n_fail  = 0;
    string cur     = "init";

    memory_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .wb_branch_hazard(wb_branch_hazard),
        .input_reg_pc(input_reg_pc), .input_mem_fun(input_mem_fun),
        .input_alu_out(input_alu_out), .input_rs2_data(input_rs2_data),
        .input_rf_wen(input_rf_wen), .input_wb_sel(input_wb_sel),
        .input_wb_addr(input_wb_addr), .output_stall_flg(output_stall_flg),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wen(mem_cmd_wen),
        .mem_cmd_wmask(mem_cmd_wmask), .mem_cmd_wdata(mem_cmd_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .output_reg_pc(output_reg_pc), .output_rf_wen(output_rf_wen),
        .output_wb_sel(output_wb_sel), .output_wb_addr(output_wb_addr),
        .output_alu_out(output_alu_out), .output_mem_rdata(output_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur, tag, got, exp);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic m_store(input logic [3:0] f);
        return f >= MEM_SB && f <= MEM_SW;
    endfunction

    function automatic logic [31:0] m_mask(input logic [3:0] f, input logic [31:0] a);
        int unsigned b = a % 4;
        if (f == MEM_SB) return 32'(1 << b);
        if (f == MEM_SH) return (b >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] f, input logic [31:0] d);
        if (f == MEM_SB) return (d % 256) * 32'h0101_0101;
        if (f == MEM_SH) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] f, input logic [31:0] a,
                                           input logic [31:0] w);
        int unsigned b   = a % 4;
        logic [31:0] byt = (w >> (8 * b)) % 256;
        logic [31:0] hw  = (w >> (16 * (b / 2))) % 65536;
        case (f)
            MEM_LB:  return (byt >= 128) ? byt - 32'd256 : byt;
            MEM_LBU: return byt;
            MEM_LH:  return (hw >= 32768) ? hw - 32'd65536 : hw;
            MEM_LHU: return hw;
            default: return w;
        endcase
    endfunction

    // ---------------- drive / observe helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        input_reg_pc   = REGPC_NOP;
        input_mem_fun  = MEM_X;
        input_alu_out  = DATA_NOP;
        input_rs2_data = $urandom;
        input_rf_wen   = REN_X;
        input_wb_sel   = WB_X;
        input_wb_addr  = 5'd0;
    endtask

    // Upstream values that must be ignored while the stage is busy
    task automatic drive_garbage();
        input_reg_pc   = $urandom;
        input_mem_fun  = 4'($urandom_range(0, 8));
        input_alu_out  = $urandom;
        input_rs2_data = $urandom;
        input_rf_wen   = 1'($urandom);
        input_wb_sel   = 4'($urandom);
        input_wb_addr  = 5'($urandom);
    endtask

    task automatic check_wb(input string tag, input logic [31:0] pc, input logic rf_wen,
                            input logic [3:0] wb_sel, input logic [4:0] wb_addr,
                            input logic [31:0] alu, input logic [31:0] rdata);
        check({tag, "_pc"},    output_reg_pc,    pc);
        check({tag, "_wen"},   output_rf_wen,    rf_wen);
        check({tag, "_sel"},   output_wb_sel,    wb_sel);
        check({tag, "_waddr"}, output_wb_addr,   wb_addr);
        check({tag, "_alu"},   output_alu_out,   alu);
        check({tag, "_rdata"}, output_mem_rdata, rdata);
    endtask

    task automatic check_bubble(input string tag);
        check_wb(tag, REGPC_NOP, REN_X, WB_X, 5'd0, DATA_NOP, DATA_NOP);
    endtask

    // Called at #1 after the edge that ends the op, with state idle.
    task automatic tail(input logic done, input logic [31:0] pc, input logic rf_wen,
                        input logic [3:0] wb_sel, input logic [4:0] wb_addr,
                        input logic [31:0] alu, input logic [31:0] rdata);
        drive_idle();
        @(negedge clk);
        if (done) check_wb("result", pc, rf_wen, wb_sel, wb_addr, alu, rdata);
        else      check_bubble("squashed");
        check("tail_stall", output_stall_flg, 1'b0);
        step();
        @(negedge clk);
        check_bubble("after");
        step();
    endtask

    // One op from execute. fs: 0 no flush, 1 flush in IDLE, 2 flush at REQ
    // cycle fa, 3 flush at WAIT cycle fa.
    task automatic do_op(input logic [3:0] fun, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [31:0] rdata, input logic rf_wen,
                         input logic [3:0] wb_sel, input logic [4:0] wb_addr,
                         input int ready_wait, input int rsp_wait, input int fs, input int fa);
        logic st      = m_store(fun);
        logic drained = 1'b0;
        logic flushed = 1'b0;
        input_reg_pc   = pc;
        input_mem_fun  = fun;
        input_alu_out  = alu;
        input_rs2_data = rs2;
        input_rf_wen   = rf_wen;
        input_wb_sel   = wb_sel;
        input_wb_addr  = wb_addr;
        wb_branch_hazard = (fs == 1);
        @(negedge clk);
        check("idle_stall", output_stall_flg, fun != MEM_X);
        check("idle_valid", mem_cmd_valid, 1'b0);
        step();
        wb_branch_hazard = 1'b0;
        if (fun == MEM_X || fs == 1) begin
            tail(fs != 1, pc, rf_wen, wb_sel, wb_addr, alu, DATA_NOP);
            return;
        end
        // Request phase
        for (int i = 0; i <= ready_wait; i++) begin
            drive_garbage();
            mem_cmd_ready    = (i == ready_wait);
            wb_branch_hazard = (fs == 2 && i == fa);
            mem_rsp_valid    = ($urandom_range(0, 3) == 0);
            mem_rsp_rdata    = $urandom;
            @(negedge clk);
            check("req_valid", mem_cmd_valid, !wb_branch_hazard);
            check("req_stall", output_stall_flg, !(st && mem_cmd_ready));
            if (!wb_branch_hazard) begin
                check("req_addr", mem_cmd_addr, alu & 32'hffff_fffc);
                check("req_wen", mem_cmd_wen, st);
                if (st) begin
                    check("req_mask", mem_cmd_wmask, m_mask(fun, alu));
                    check("req_wdata", mem_cmd_wdata, m_wdata(fun, rs2));
                end
            end
            check("req_out_pc", output_reg_pc, REGPC_NOP);
            check("req_out_wen", output_rf_wen, REN_X);
            flushed = wb_branch_hazard;
            step();
            if (flushed) break;
        end
        mem_cmd_ready    = 1'b0;
        mem_rsp_valid    = 1'b0;
        wb_branch_hazard = 1'b0;
        if (flushed || st) begin
            tail(!flushed, pc, rf_wen, wb_sel, wb_addr, alu, DATA_NOP);
            return;
        end
        // Response phase
        for (int j = 0; j <= rsp_wait; j++) begin
            drive_garbage();
            mem_rsp_valid    = (j == rsp_wait);
            mem_rsp_rdata    = mem_rsp_valid ? rdata : $urandom;
            wb_branch_hazard = (fs == 3 && j == fa);
            @(negedge clk);
            check("wait_valid", mem_cmd_valid, 1'b0);
            check("wait_stall", output_stall_flg, drained ? 1'b1 : !mem_rsp_valid);
            check("wait_out_wen", output_rf_wen, REN_X);
            if (wb_branch_hazard) flushed = 1'b1;
            if (wb_branch_hazard && !mem_rsp_valid) drained = 1'b1;
            step();
        end
        mem_rsp_valid    = 1'b0;
        wb_branch_hazard = 1'b0;
        tail(!flushed, pc, rf_wen, wb_sel, wb_addr, alu, m_load(fun, alu, rdata));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        wb_branch_hazard = 1'b0;
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'd0;
        drive_idle();
        cur = "reset";
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bubble("rst");
        check("rst_valid", mem_cmd_valid, 1'b0);
        step();
        rst = 1'b0;

        cur = "add";
        do_op(MEM_X, 32'h40, 32'h5, 32'h0, 32'h0, 1'b1, 4'd1, 5'd3, 0, 0, 0, 0);
        cur = "lb";
        do_op(MEM_LB, 32'h44, 32'h103, 32'h0, 32'h80FF_FFFF, 1'b1, 4'd2, 5'd4, 0, 1, 0, 0);
        cur = "sh";
        do_op(MEM_SH, 32'h48, 32'h202, 32'h1234_ABCD, 32'h0, 1'b0, 4'd0, 5'd0, 3, 0, 0, 0);
        cur = "lhu";
        do_op(MEM_LHU, 32'h4c, 32'h2, 32'h0, 32'h8001_7FFF, 1'b1, 4'd2, 5'd5, 1, 0, 0, 0);
        cur = "lh";
        do_op(MEM_LH, 32'h50, 32'h2, 32'h0, 32'h8001_7FFF, 1'b1, 4'd2, 5'd6, 0, 2, 0, 0);
        cur = "lw_drain";
        do_op(MEM_LW, 32'h54, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b1, 4'd2, 5'd7, 0, 3, 3, 0);
        cur = "after_drain";
        do_op(MEM_X, 32'h58, 32'h77, 32'h0, 32'h0, 1'b1, 4'd1, 5'd8, 0, 0, 0, 0);
        cur = "sw_flush_req";
        do_op(MEM_SW, 32'h5c, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b0, 4'd0, 5'd0, 0, 0, 2, 0);
        cur = "lw_flush_rsp";
        do_op(MEM_LW, 32'h60, 32'h404, 32'h0, 32'h1111_2222, 1'b1, 4'd2, 5'd9, 0, 1, 3, 1);

        // Reset while a request is outstanding
        cur = "rst_req";
        input_mem_fun = MEM_LW;
        input_alu_out = 32'h500;
        input_reg_pc  = 32'h64;
        input_rf_wen  = 1'b1;
        step();
        @(negedge clk);
        check("pre_valid", mem_cmd_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("valid", mem_cmd_valid, 1'b0);
        check_bubble("out");
        step();
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", mem_cmd_valid, 1'b0);
        check("idle_stall", output_stall_flg, 1'b0);
        step();
        cur = "post_rst";
        do_op(MEM_X, 32'h68, 32'h99, 32'h0, 32'h0, 1'b1, 4'd1, 5'd10, 0, 0, 0, 0);

        // Randomised ops
        for (int k = 0; k < 150; k++) begin
            logic [3:0] f  = 4'($urandom_range(0, 8));
            int         rw = $urandom_range(0, 3);
            int         sw = $urandom_range(0, 3);
            int         fs = 0;
            int         fa = 0;
            if ($urandom_range(0, 5) == 0) begin
                fs = $urandom_range(1, 3);
                fa = (fs == 2) ? $urandom_range(0, rw) : $urandom_range(0, sw);
            end
            cur = $sformatf("rand%0d", k);
            do_op(f, $urandom, $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom),
                  5'($urandom), rw, sw, fs, fa);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
